player_link_tx: RTL and testbench
=================================

# player_link_tx

Serial transmitter that packs the local player's state (ID, direction, x/y location, player state) into a fixed 4-byte packet and sends it over a single-wire UART-style link to the main FPGA once per video frame. It sits on a secondary FPGA between `game_logic`, which produces `local_*` player signals, and the board-to-board link pin. The main FPGA's receiver turns the link back into `playerN_*` inputs for `main_FPGA_control`.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per serial bit (25 MHz / 115200 baud); minimum 2.
- `clock`  in  1  25 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  frame strobe, active high, synchronous to `clock`. A rising edge requests a send.
- `send_en`  in  1  permits new packets. Deasserting it never aborts a packet already in flight.
- `player_id`  in  2  local player ID.
- `direction`  in  2  facing direction.
- `loc_x`  in  9  x location.
- `loc_y`  in  9  y location.
- `state`  in  4  player state.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  packet in flight.
- `dropped`  out  1  one-cycle pulse when a request is lost.
- `frames_sent`  out  8  count of completed packets; wraps 255→0.

## Operation
- Packet word (32 bits, MSB first): {4'hA sync, player_id, direction, loc_x, loc_y, state, 2'b00}.
- The word is sent as 4 bytes, byte 3 (bits 31:24) first.
- Each byte is framed 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
- No idle gap between bytes.
- Request condition: `vsync`=1 and registered `vsync_q`=0.
  - If `send_en`=1 and the FSM is IDLE, all payload inputs are snapshotted in that cycle. Later input changes do not affect the packet.
  - If `send_en`=1 and `busy`=1, the request is ignored and `dropped` pulses on the next cycle.
  - If `send_en`=0, the request is ignored and `dropped` stays low.
- FSM states and transitions:
  - IDLE → START on an accepted request.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → STOP after 8 bits.
  - STOP → START if more bytes remain.
  - STOP → IDLE after the last byte; `frames_sent` increments on this transition.
- Counters:
  - Baud counter: `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1 and restarts on each bit.
  - Bit index: 0..7.
  - Byte index: 0..NBYTES-1.
- Reset values, applied immediately and also mid-packet: `tx`=1, `busy`=0, `dropped`=0, `frames_sent`=0, FSM in IDLE, `vsync_q`=0. A partial packet is simply truncated; the receiver discards it because the sync nibble or length check fails.
- If a request edge coincides with the STOP→IDLE cycle, it is treated as busy and dropped. The next edge is accepted.

## Timing
- The request edge is seen in cycle N. `tx` falls (start bit) and `busy` rises registered at the N+1 clock edge.
- Each bit is held for exactly `CLKS_PER_BIT` cycles.
- Packet length: NBYTES×10×CLKS_PER_BIT cycles. That is 8680 cycles at the default, 5 bytes (10850 cycles) with checksum. Both fit easily within one 25 MHz VGA frame.
- `busy` falls in the same cycle that the last stop bit's period ends and `frames_sent` updates.
- All outputs are registered; nothing is combinational from inputs.

## Configuration
- `PLAYER_LINK_CHECKSUM_EN`
  - Defined: a fifth byte, the XOR of the 4 packet bytes, is appended in the same 8N1 framing. NBYTES=5.
  - Undefined: NBYTES=4 and no checksum logic is generated.

## Structure
- Package `overcooked_link_pkg` holds:
  - `LINK_SYNC` = 4'hA.
  - `PLAYER_PKT_BITS` = 32.
  - The typedef `player_pkt_t` (packed struct in word order).
  - The FSM enum `link_tx_state_t`, shared with the future receiver.
- Natural sub-module: `link_uart_byte_tx`, which has byte valid/ready in and `tx`/done out and owns the baud and bit counters. `player_link_tx` owns snapshotting, byte sequencing, checksum and statistics.

## Test plan
- Bench settings: `CLKS_PER_BIT`=4.
- Basic packet: snapshot id=1, dir=2, x=300, y=200, state=3, then `vsync` edge → bytes 0xA6, 0x96, 0x32, 0x0C, each 8N1 with 4 cycles per bit. `frames_sent`=1. `busy` is high for exactly 160 cycles.
- Checksum: with `PLAYER_LINK_CHECKSUM_EN` and the same stimulus → fifth byte 0x0E. `busy` is high for 200 cycles.
- Input changes: change `loc_x` to 0 in the middle of the packet → the transmitted bytes are unchanged.
- Overlapping request: a second `vsync` edge 20 cycles into a packet → one `dropped` pulse and no second packet. An edge after IDLE → a new packet is sent.
- Disabled: `send_en`=0 with edges applied → `tx` stays 1, `dropped` stays 0. Deasserting `send_en` mid-packet → the packet completes.
- Reset: assert `reset` in the middle of byte 2 → `tx`=1 and `busy`=0 without waiting for a clock edge. The next edge after release → a full packet. 256 completed packets → `frames_sent` wraps to 0.

Source files
------------

// File: rtl/overcooked_link_pkg.sv
// Shared definitions for the board-to-board player link: packet layout,
// serial FSM states and packet/byte helpers used by transmitter and receiver.
package overcooked_link_pkg;

    localparam logic [3:0] LINK_SYNC        = 4'hA;
    localparam int         PLAYER_PKT_BITS  = 32;
    localparam int         PLAYER_PKT_BYTES = PLAYER_PKT_BITS / 8;

    // Field order matches the wire order, MSB first.
    typedef struct packed {
        logic [3:0] sync;
        logic [1:0] player_id;
        logic [1:0] direction;
        logic [8:0] loc_x;
        logic [8:0] loc_y;
        logic [3:0] state;
        logic [1:0] pad;
    } player_pkt_t;

    typedef enum logic [1:0] {
        LINK_IDLE,
        LINK_START,
        LINK_DATA,
        LINK_STOP
    } link_tx_state_t;

    function automatic player_pkt_t make_pkt(
        input logic [1:0] id,
        input logic [1:0] dir,
        input logic [8:0] x,
        input logic [8:0] y,
        input logic [3:0] st
    );
        player_pkt_t p;
        p.sync      = LINK_SYNC;
        p.player_id = id;
        p.direction = dir;
        p.loc_x     = x;
        p.loc_y     = y;
        p.state     = st;
        p.pad       = 2'b00;
        return p;
    endfunction

    // Byte 'idx' in transmission order: index 0 is bits 31:24.
    function automatic logic [7:0] pkt_byte(input player_pkt_t pkt, input logic [2:0] idx);
        logic [PLAYER_PKT_BITS-1:0] w;
        logic [7:0]                 b;
        w = pkt;
        case (idx)
            3'd0:    b = w[31:24];
            3'd1:    b = w[23:16];
            3'd2:    b = w[15:8];
            3'd3:    b = w[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/player_link_tx_if.sv
// Player-state and link-status signals between game_logic and the link
// transmitter; master is the game side, slave is player_link_tx.
interface player_link_tx_if;

    logic       vsync;
    logic       send_en;
    logic [1:0] player_id;
    logic [1:0] direction;
    logic [8:0] loc_x;
    logic [8:0] loc_y;
    logic [3:0] state;
    logic       tx;
    logic       busy;
    logic       dropped;
    logic [7:0] frames_sent;

    modport master (
        output vsync, send_en, player_id, direction, loc_x, loc_y, state,
        input  tx, busy, dropped, frames_sent
    );

    modport slave (
        input  vsync, send_en, player_id, direction, loc_x, loc_y, state,
        output tx, busy, dropped, frames_sent
    );

endinterface

// File: rtl/link_uart_byte_tx.sv
// 8N1 byte serializer with valid/ready input; accepts the next byte in the
// last cycle of a stop bit so consecutive bytes go out without an idle gap.
module link_uart_byte_tx
    import overcooked_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_done
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    link_tx_state_t    r_state;
    link_tx_state_t    w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_data;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_baud_last;
    logic              w_load;

    assign w_baud_last = (r_baud == BAUD_LAST);
    assign o_done      = (r_state == LINK_STOP) && w_baud_last;
    assign o_ready     = (r_state == LINK_IDLE) || o_done;
    assign w_load      = i_valid && o_ready;
    assign o_tx        = r_tx;

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        case (r_state)
            LINK_IDLE: begin
                if (i_valid) w_state_next = LINK_START;
            end
            LINK_START: begin
                if (w_baud_last) begin
                    w_state_next = LINK_DATA;
                    w_bit_next   = 3'd0;
                end
            end
            LINK_DATA: begin
                if (w_baud_last) begin
                    if (r_bit == 3'd7) w_state_next = LINK_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            LINK_STOP: begin
                if (w_baud_last) w_state_next = i_valid ? LINK_START : LINK_IDLE;
            end
            default: w_state_next = LINK_IDLE;
        endcase
    end

    // Line level is decided from the next state so tx is a clean flop output.
    always_comb begin
        case (w_state_next)
            LINK_START: w_tx_next = 1'b0;
            LINK_DATA:  w_tx_next = r_data[w_bit_next];
            default:    w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= LINK_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_baud  <= (r_state == LINK_IDLE || w_baud_last) ? '0 : r_baud + 1'b1;
        end
    end

    // NOTE: the byte buffer carries no reset; it is only read after a load.
    always_ff @(posedge clock) begin
        if (w_load) r_data <= i_data;
    end

endmodule

// File: rtl/player_link_tx.sv
// Per-frame player-state packet transmitter: snapshots the payload on a vsync
// edge and sends it as 8N1 bytes. Define PLAYER_LINK_CHECKSUM_EN to append an XOR byte.
module player_link_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             clock,
    input  logic             reset,
    player_link_tx_if.slave  link
);

    import overcooked_link_pkg::*;

`ifdef PLAYER_LINK_CHECKSUM_EN
    localparam int NBYTES = PLAYER_PKT_BYTES + 1;
`else
    localparam int NBYTES = PLAYER_PKT_BYTES;
`endif
    localparam int               IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    logic             r_vsync_q;
    logic             r_busy;
    logic             r_dropped;
    logic [7:0]       r_frames_sent;
    logic [IDX_W-1:0] r_byte_idx;
    player_pkt_t      r_pkt;

    player_pkt_t      w_live_pkt;
    logic             w_req;
    logic             w_accept;
    logic             w_drop;
    logic             w_last_byte;
    logic             w_more;
    logic             w_byte_valid;
    logic             w_byte_ready;
    logic             w_byte_done;
    logic             w_tx;
    logic [7:0]       w_byte_data;
    logic [7:0]       w_next_byte;
    logic [IDX_W-1:0] w_next_idx;

    assign w_live_pkt = make_pkt(link.player_id, link.direction, link.loc_x,
                                 link.loc_y, link.state);

    assign w_req       = link.vsync & ~r_vsync_q;
    assign w_accept    = w_req & link.send_en & ~r_busy & w_byte_ready;
    assign w_drop      = w_req & link.send_en & r_busy;
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_more      = r_busy & w_byte_done & ~w_last_byte;
    assign w_next_idx  = r_byte_idx + 1'b1;

`ifdef PLAYER_LINK_CHECKSUM_EN
    logic [7:0] w_checksum;
    assign w_checksum  = pkt_byte(r_pkt, 3'd0) ^ pkt_byte(r_pkt, 3'd1) ^
                         pkt_byte(r_pkt, 3'd2) ^ pkt_byte(r_pkt, 3'd3);
    assign w_next_byte = (w_next_idx == IDX_W'(PLAYER_PKT_BYTES)) ? w_checksum
                                                                   : pkt_byte(r_pkt, 3'(w_next_idx));
`else
    assign w_next_byte = pkt_byte(r_pkt, 3'(w_next_idx));
`endif

    // The first byte comes straight from the live inputs so the start bit
    // leaves on the edge that takes the snapshot.
    assign w_byte_valid = w_accept | w_more;
    assign w_byte_data  = w_accept ? pkt_byte(w_live_pkt, 3'd0) : w_next_byte;

    link_uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clock   (clock),
        .reset   (reset),
        .i_valid (w_byte_valid),
        .i_data  (w_byte_data),
        .o_ready (w_byte_ready),
        .o_tx    (w_tx),
        .o_done  (w_byte_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vsync_q     <= 1'b0;
            r_busy        <= 1'b0;
            r_dropped     <= 1'b0;
            r_frames_sent <= 8'd0;
            r_byte_idx    <= '0;
        end else begin
            r_vsync_q <= link.vsync;
            r_dropped <= w_drop;
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_byte_idx <= '0;
            end else if (r_busy && w_byte_done) begin
                if (w_last_byte) begin
                    r_busy        <= 1'b0;
                    r_byte_idx    <= '0;
                    r_frames_sent <= r_frames_sent + 8'd1;
                end else begin
                    r_byte_idx <= w_next_idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) r_pkt <= w_live_pkt;
    end

    assign link.tx          = w_tx;
    assign link.busy        = r_busy;
    assign link.dropped     = r_dropped;
    assign link.frames_sent = r_frames_sent;

endmodule

// File: tb/tb_player_link_tx.sv
// Directed bench for player_link_tx: a serial monitor decodes tx and checks each
// byte against a scoreboard queue filled when a packet request is issued.
module tb_player_link_tx;

    localparam int CPB = 4;
`ifdef PLAYER_LINK_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int PKT_CYCLES = NB * 10 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    int         total = 0;
    int         bad   = 0;
    int         exp_frames = 0;
    logic [7:0] exp_q[$];
    bit         rst_abort = 1'b0;

    player_link_tx_if link ();

    player_link_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock (clk),
        .reset (reset),
        .link  (link)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] id, input logic [1:0] dir,
                                               input logic [8:0] x, input logic [8:0] y,
                                               input logic [3:0] st);
        return {4'hA, id, dir, x, y, st, 2'b00};
    endfunction

    task automatic push_expected(input logic [31:0] w);
        logic [7:0] cs;
        cs = 8'h00;
        for (int k = 3; k >= 0; k--) begin
            exp_q.push_back(w[8*k +: 8]);
            cs = cs ^ w[8*k +: 8];
        end
`ifdef PLAYER_LINK_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic set_payload(input logic [1:0] id, input logic [1:0] dir,
                               input logic [8:0] x, input logic [8:0] y, input logic [3:0] st);
        link.player_id = id;
        link.direction = dir;
        link.loc_x     = x;
        link.loc_y     = y;
        link.state     = st;
    endtask

    task automatic pulse_vsync();
        @(posedge clk); #1;
        link.vsync = 1'b1;
        @(posedge clk); #1;
        link.vsync = 1'b0;
    endtask

    // Issues a request, then tracks busy cycle by cycle; 'action' injects a
    // disturbance at a fixed point of the packet.
    task automatic run_packet(input int action, output int cyc, output int drops);
        pulse_vsync();
        check("busy_rise", link.busy, 1);
        check("start_bit", link.tx, 0);
        cyc   = 0;
        drops = 0;
        while (cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (link.dropped === 1'b1) drops++;
            case (action)
                1: begin
                    if (cyc == 50) begin
                        link.loc_x = 9'd0;
                        link.state = 4'hF;
                    end
                end
                2: begin
                    if (cyc == 20)      link.vsync = 1'b1;
                    else if (cyc == 21) link.vsync = 1'b0;
                end
                3: begin
                    if (cyc == 20) link.send_en = 1'b0;
                end
                4: begin
                    if (cyc == PKT_CYCLES - 1)  link.vsync = 1'b1;
                    else if (cyc == PKT_CYCLES) link.vsync = 1'b0;
                end
                default: ;
            endcase
            if (link.busy !== 1'b1) break;
        end
    endtask

    initial begin : monitor
        logic [7:0] got;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (rst_abort) begin
                exp_q.delete();
                rst_abort = 1'b0;
            end else if (reset === 1'b0 && link.tx === 1'b0) begin
                aborted = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (rst_abort) begin
                        aborted = 1'b1;
                        break;
                    end
                    got[i] = link.tx;
                end
                if (!aborted) begin
                    repeat (CPB) @(negedge clk);
                    if (rst_abort) aborted = 1'b1;
                end
                if (aborted) begin
                    exp_q.delete();
                    rst_abort = 1'b0;
                end else begin
                    check("stop_bit", link.tx, 1);
                    check("byte_queued", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("tx_byte", got, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int   cyc;
        int   drops;
        logic min_tx;
        logic max_drop;

        reset         = 1'b1;
        link.vsync    = 1'b0;
        link.send_en  = 1'b1;
        set_payload(2'd1, 2'd2, 9'd300, 9'd200, 4'd3);
        repeat (3) @(posedge clk); #1;
        check("reset_tx", link.tx, 1);
        check("reset_busy", link.busy, 0);
        check("reset_dropped", link.dropped, 0);
        check("reset_frames", link.frames_sent, 0);
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Basic packet with the literal byte sequence.
        exp_q.push_back(8'hA6);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h32);
        exp_q.push_back(8'h0C);
`ifdef PLAYER_LINK_CHECKSUM_EN
        exp_q.push_back(8'h0E);
`endif
        run_packet(0, cyc, drops);
        exp_frames++;
        check("basic_busy_cycles", cyc, PKT_CYCLES);
        check("basic_drops", drops, 0);
        check("basic_frames", link.frames_sent, exp_frames);
        check("basic_queue_empty", exp_q.size(), 0);
        check("basic_idle_tx", link.tx, 1);

        // Payload changes mid-packet must not reach the wire.
        set_payload(2'd2, 2'd1, 9'd17, 9'd400, 4'd9);
        push_expected(model_word(2'd2, 2'd1, 9'd17, 9'd400, 4'd9));
        run_packet(1, cyc, drops);
        exp_frames++;
        check("snap_busy_cycles", cyc, PKT_CYCLES);
        check("snap_frames", link.frames_sent, exp_frames);
        check("snap_queue_empty", exp_q.size(), 0);

        // Overlapping request 20 cycles in.
        set_payload(2'd3, 2'd0, 9'd511, 9'd1, 4'd6);
        push_expected(model_word(2'd3, 2'd0, 9'd511, 9'd1, 4'd6));
        run_packet(2, cyc, drops);
        exp_frames++;
        check("overlap_busy_cycles", cyc, PKT_CYCLES);
        check("overlap_drops", drops, 1);
        repeat (20) @(posedge clk); #1;
        check("overlap_no_second", link.busy, 0);
        check("overlap_frames", link.frames_sent, exp_frames);
        check("overlap_queue_empty", exp_q.size(), 0);

        // Edge after IDLE is accepted.
        set_payload(2'd0, 2'd3, 9'd128, 9'd255, 4'd12);
        push_expected(model_word(2'd0, 2'd3, 9'd128, 9'd255, 4'd12));
        run_packet(0, cyc, drops);
        exp_frames++;
        check("after_idle_cycles", cyc, PKT_CYCLES);
        check("after_idle_frames", link.frames_sent, exp_frames);

        // Edge coinciding with STOP->IDLE is dropped; the next one is accepted.
        set_payload(2'd1, 2'd1, 9'd42, 9'd84, 4'd5);
        push_expected(model_word(2'd1, 2'd1, 9'd42, 9'd84, 4'd5));
        run_packet(4, cyc, drops);
        exp_frames++;
        check("coincide_cycles", cyc, PKT_CYCLES);
        check("coincide_drops", drops, 1);
        repeat (10) @(posedge clk); #1;
        check("coincide_no_packet", link.busy, 0);
        check("coincide_queue_empty", exp_q.size(), 0);
        push_expected(model_word(2'd1, 2'd1, 9'd42, 9'd84, 4'd5));
        run_packet(0, cyc, drops);
        exp_frames++;
        check("coincide_next_cycles", cyc, PKT_CYCLES);
        check("coincide_next_frames", link.frames_sent, exp_frames);

        // Disabled: edges are ignored silently.
        link.send_en = 1'b0;
        min_tx   = 1'b1;
        max_drop = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            link.vsync = ((i % 10) < 5);
            min_tx   = min_tx & link.tx;
            max_drop = max_drop | link.dropped;
        end
        link.vsync = 1'b0;
        check("disabled_tx", min_tx, 1);
        check("disabled_dropped", max_drop, 0);
        check("disabled_busy", link.busy, 0);
        check("disabled_frames", link.frames_sent, exp_frames);

        // send_en dropped mid-packet: the packet still completes.
        link.send_en = 1'b1;
        set_payload(2'd2, 2'd2, 9'd99, 9'd33, 4'd10);
        push_expected(model_word(2'd2, 2'd2, 9'd99, 9'd33, 4'd10));
        run_packet(3, cyc, drops);
        exp_frames++;
        check("en_off_cycles", cyc, PKT_CYCLES);
        check("en_off_frames", link.frames_sent, exp_frames);
        check("en_off_queue_empty", exp_q.size(), 0);
        link.send_en = 1'b1;

        // Reset in the middle of the third byte (data bit 2 of 0x32 is 0).
        set_payload(2'd1, 2'd2, 9'd300, 9'd200, 4'd3);
        push_expected(model_word(2'd1, 2'd2, 9'd300, 9'd200, 4'd3));
        pulse_vsync();
        repeat (93) @(posedge clk); #1;
        check("pre_reset_tx", link.tx, 0);
        reset     = 1'b1;
        rst_abort = 1'b1;
        #1;
        check("async_reset_tx", link.tx, 1);
        check("async_reset_busy", link.busy, 0);
        check("async_reset_frames", link.frames_sent, 0);
        exp_frames = 0;
        repeat (6) @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("post_reset_queue_flushed", exp_q.size(), 0);

        push_expected(model_word(2'd1, 2'd2, 9'd300, 9'd200, 4'd3));
        run_packet(0, cyc, drops);
        exp_frames++;
        check("post_reset_cycles", cyc, PKT_CYCLES);
        check("post_reset_frames", link.frames_sent, exp_frames);

        // Drive the frame counter through its wrap.
        for (int i = 0; i < 255; i++) begin
            set_payload(2'(i), 2'(i >> 2), 9'(i * 7), 9'(511 - i), 4'(i));
            push_expected(model_word(2'(i), 2'(i >> 2), 9'(i * 7), 9'(511 - i), 4'(i)));
            run_packet(0, cyc, drops);
            exp_frames = (exp_frames + 1) % 256;
            check("wrap_cycles", cyc, PKT_CYCLES);
            check("wrap_frames", link.frames_sent, exp_frames);
        end
        check("frames_wrapped_zero", link.frames_sent, 0);
        check("final_queue_empty", exp_q.size(), 0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
